// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bus of the data-memory arbiter.
// slave: arbiter side; master: requester/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_we;
  logic [1:0]        req0_size;
  logic [DATA_W-1:0] req0_wdata;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_we;
  logic [1:0]        req1_size;
  logic [DATA_W-1:0] req1_wdata;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_write;
  logic [1:0]        mem_access_size;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  req_valid, req0_addr, req0_we, req0_size, req0_wdata,
           req1_addr, req1_we, req1_size, req1_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );

  modport master (
    output req_valid, req0_addr, req0_we, req0_size, req0_wdata,
           req1_addr, req1_we, req1_size, req1_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the byte-addressed data memory.
// Define DMEM_ARB_ERR_EN to enable size/alignment/range checking with rsp_err.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              gnt;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt = 1'b0;
    case (bus.req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
  end

  assign accept    = (state_q == S_IDLE) && (bus.req_valid != 2'b00);
  assign sel_addr  = gnt ? bus.req1_addr  : bus.req0_addr;
  assign sel_we    = gnt ? bus.req1_we    : bus.req0_we;
  assign sel_size  = gnt ? bus.req1_size  : bus.req0_size;
  assign sel_wdata = gnt ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

`ifdef DMEM_ARB_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  logic [ADDR_W:0] nbytes;
  logic [ADDR_W:0] end_addr;

  // One extra bit on the end address so addr+bytes cannot wrap past the check.
  always_comb begin
    nbytes = '0;
    case (sel_size)
      2'd0:    nbytes[2:0] = 3'd1;
      2'd1:    nbytes[2:0] = 3'd2;
      2'd2:    nbytes[2:0] = 3'd4;
      default: nbytes = '0;
    endcase
    end_addr = {1'b0, sel_addr} + nbytes;
    sel_err  = (sel_size == 2'd3)
            || ((sel_size == 2'd1) && sel_addr[0])
            || ((sel_size == 2'd2) && (sel_addr[1:0] != 2'b00))
            || (end_addr > DEPTH_L);
  end

  assign bus.rsp_err = (state_q == S_DONE) && err_q;
`else
  assign sel_err     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_BUSY : S_IDLE;
      S_BUSY:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt;
        last_q  <= gnt;
        addr_q  <= sel_addr;
        we_q    <= sel_we;
        size_q  <= sel_size;
        wdata_q <= sel_wdata;
        err_q   <= sel_err;
      end
      if (state_q == S_BUSY) begin
        rdata_q <= (we_q || err_q) ? '0 : bus.mem_data_out;
      end
    end
  end

  assign bus.mem_address     = addr_q;
  assign bus.mem_access_size = size_q;
  assign bus.mem_data_in     = wdata_q;
  assign bus.mem_read_write  = (state_q == S_BUSY) && we_q && !err_q;

  assign bus.rsp_valid = (state_q == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a 32-byte sync-write/comb-read memory.
// Directed vectors; expected responses are queued at acceptance and checked on rsp_valid.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: little-endian, size 3 ignored, out-of-range bytes ignored / read as 0.
  logic [7:0] mem [32] = '{default: 8'h00};

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return (a < 32) ? mem[a[4:0]] : 8'h00;
  endfunction

  assign bus.mem_data_out = {rdb(bus.mem_address + 3), rdb(bus.mem_address + 2),
                             rdb(bus.mem_address + 1), rdb(bus.mem_address)};

  always @(posedge clk) begin
    if (bus.mem_read_write) begin
      int n;
      n = (bus.mem_access_size == 2'd0) ? 1 :
          (bus.mem_access_size == 2'd1) ? 2 :
          (bus.mem_access_size == 2'd2) ? 4 : 0;
      for (int i = 0; i < n; i++)
        if (bus.mem_address + 32'(i) < 32)
          mem[5'(bus.mem_address + 32'(i))] <= bus.mem_data_in[8*i +: 8];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid != 2'b00) begin
      exp_t e;
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b want none", bus.rsp_valid);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", {30'd0, bus.rsp_valid}, (e.port == 1) ? 32'd2 : 32'd1);
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_fields(input int p, input logic [31:0] a, input logic we,
                            input logic [1:0] sz, input logic [31:0] wd);
    if (p == 0) begin
      bus.req0_addr = a; bus.req0_we = we; bus.req0_size = sz; bus.req0_wdata = wd;
    end else begin
      bus.req1_addr = a; bus.req1_we = we; bus.req1_size = sz; bus.req1_wdata = wd;
    end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
    int t;
    t = 0;
    set_fields(p, a, we, sz, wd);
    bus.req_valid[p] = 1'b1;
    @(negedge clk);
    while (!bus.req_ready[p] && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("accept", {31'd0, bus.req_ready[p]}, 32'd1);
    if (bus.req_ready[p]) sb.push_back('{p, er, ee, cyc + 2});
    @(posedge clk);
    #1;
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int prev;
    int n;
    int t;
    bit r1seen;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    set_fields(0, '0, 1'b0, 2'd0, '0);
    set_fields(1, '0, 1'b0, 2'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_read_write}, 32'd0);
    check("rst_mem_addr", bus.mem_address, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: word store then load on port 0; extra word on port 1 for later
    issue(0, 32'h8, 1'b1, 2'd2, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(0, 32'h8, 1'b0, 2'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1, 32'h4, 1'b1, 2'd2, 32'h0BADF00D, 32'h0, 1'b0);
    issue(1, 32'h4, 1'b0, 2'd2, 32'h0, 32'h0BADF00D, 1'b0);

    // T2: both valid straight out of reset; port 0 first, then alternation
    repeat (3) @(posedge clk);
    do_reset();
    set_fields(0, 32'h8, 1'b0, 2'd2, 32'h0);
    set_fields(1, 32'h4, 1'b0, 2'd2, 32'h0);
    bus.req_valid = 2'b11;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      @(negedge clk);
      while (bus.req_ready == 2'b00 && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("t2_grant", {30'd0, bus.req_ready}, (k % 2 == 1) ? 32'd2 : 32'd1);
      sb.push_back('{k % 2, (k % 2 == 1) ? 32'h0BADF00D : 32'hDEADBEEF, 1'b0, cyc + 2});
      if (prev >= 0) check("t2_spacing", cyc - prev, 32'd3);
      prev = cyc;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 2'b00;

    // T3: byte and half stores merge into the existing word
    issue(1, 32'h9, 1'b1, 2'd0, 32'hFFFFFFA5, 32'h0, 1'b0);
    issue(0, 32'h8, 1'b0, 2'd2, 32'h0, 32'hDEADA5EF, 1'b0);
    issue(1, 32'hA, 1'b1, 2'd1, 32'hFFFF1234, 32'h0, 1'b0);
    issue(0, 32'h8, 1'b0, 2'd2, 32'h0, 32'h1234A5EF, 1'b0);

    // Reserved size 3: response still issued, memory untouched
    issue(0, 32'h14, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h0, ERR_EN);
    issue(0, 32'h14, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);

    // T4: reset during BUSY of a store aborts it
    set_fields(0, 32'h10, 1'b1, 2'd2, 32'h12345678);
    bus.req_valid[0] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready[0] && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t4_accept", {31'd0, bus.req_ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    check("t4_busy_we", {31'd0, bus.mem_read_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_we", {31'd0, bus.mem_read_write}, 32'd0);
    check("t4_rst_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(0, 32'h10, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);

`ifdef DMEM_ARB_ERR_EN
    // T5: misaligned word load and out-of-range half store are rejected
    issue(0, 32'h2, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1);
    issue(1, 32'h1F, 1'b1, 2'd1, 32'h0000BEEF, 32'h0, 1'b1);
    issue(0, 32'h1C, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
    issue(1, 32'h1C, 1'b1, 2'd2, 32'hC0DE0001, 32'h0, 1'b0);
    issue(0, 32'h1C, 1'b0, 2'd2, 32'h0, 32'hC0DE0001, 1'b0);
`endif

    // T6: port 0 held valid, port 1 idle: one accept every 3 cycles
    repeat (4) @(posedge clk);
    #1;
    set_fields(0, 32'h8, 1'b0, 2'd2, 32'h0);
    bus.req_valid = 2'b01;
    prev = -1;
    n = 0;
    r1seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.req_ready[1]) r1seen = 1'b1;
      if (bus.req_ready[0]) begin
        sb.push_back('{0, 32'h1234A5EF, 1'b0, cyc + 2});
        if (prev >= 0) check("t6_spacing", cyc - prev, 32'd3);
        prev = cyc;
        n++;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    check("t6_accepts", n, 32'd4);
    check("t6_ready1", {31'd0, r1seen}, 32'd0);

    repeat (6) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
